// File: rtl/alu_issue_ctrl.sv
// Serialized issue controller for an external 4-bit ALU: accepts one instruction,
// drives registered ALU operands for one EXEC cycle, then writes the result back.
module alu_issue_ctrl #(
  parameter bit LDI_SETS_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_instr,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_op,
  input  logic [3:0]  alu_result,
  input  logic        alu_zero,
  output logic        wb_valid,
  output logic [1:0]  wb_rd,
  output logic [3:0]  wb_data,
  output logic        zero_flag,
  output logic        halted,
  input  logic [1:0]  dbg_addr,
  output logic [3:0]  dbg_data
);

  // Handshake: an instruction transfers on a rising edge where in_valid and
  // in_ready are both 1; in_ready depends only on state, never on in_valid.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_NOP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t      state;
  state_t      state_next;
  logic [3:0]  regs [4];
  logic [2:0]  op_q;
  logic [1:0]  rd_q;
  logic        accept;
  logic [2:0]  in_op;
  logic [1:0]  in_rd;
  logic [1:0]  in_rs1;
  logic [1:0]  in_rs2;
  logic [3:0]  in_imm;
  logic        exec_writes;
  logic        exec_sets_zero;

  assign in_op  = in_instr[11:9];
  assign in_rd  = in_instr[8:7];
  assign in_rs1 = in_instr[6:5];
  assign in_rs2 = in_instr[4:3];
  assign in_imm = in_instr[3:0];

  assign accept = in_valid && in_ready;

  // Every op except NOP (and HALT, which never reaches EXEC) writes back.
  assign exec_writes    = (op_q <= OP_LDI);
  assign exec_sets_zero = (op_q < OP_LDI) || ((op_q == OP_LDI) && LDI_SETS_ZERO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = (in_op == OP_HALT) ? HALT : EXEC;
        end
      end
      EXEC:    state_next = IDLE;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    halted   = (state == HALT);
  end

  // Operand capture on the accepting edge; register values are those current
  // at that edge, so rd==rs1/rs2 needs no forwarding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= 4'd0;
      alu_b  <= 4'd0;
      alu_op <= 3'b000;
      op_q   <= 3'b000;
      rd_q   <= 2'd0;
    end else if (accept && (in_op != OP_HALT)) begin
      op_q <= in_op;
      rd_q <= in_rd;
      if (in_op == OP_LDI) begin
        alu_a  <= in_imm;
        alu_b  <= 4'd0;
        alu_op <= 3'b001;
      end else if (in_op == OP_NOP) begin
        alu_a  <= 4'd0;
        alu_b  <= 4'd0;
        alu_op <= 3'b000;
      end else begin
        alu_a  <= regs[in_rs1];
        alu_b  <= regs[in_rs2];
        alu_op <= in_op;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 4'd0;
      end
      wb_valid  <= 1'b0;
      wb_rd     <= 2'd0;
      wb_data   <= 4'd0;
      zero_flag <= 1'b0;
    end else if ((state == EXEC) && exec_writes) begin
      regs[rd_q] <= alu_result;
      wb_valid   <= 1'b1;
      wb_rd      <= rd_q;
      wb_data    <= alu_result;
      if (exec_sets_zero) begin
        zero_flag <= alu_zero;
      end
    end else begin
      wb_valid <= 1'b0;
    end
  end

  assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (LDI_SETS_ZERO=1 and 0) share stimulus,
// each with its own ALU model, checked against an instruction-level reference.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [11:0] in_instr = 12'd0;
  logic [1:0]  dbg_addr = 2'd0;

  logic        in_ready1, in_ready0;
  logic [3:0]  a1, b1, a0, b0, res1, res0;
  logic [2:0]  op1, op0;
  logic        wbv1, wbv0, zf1, zf0, halted1, halted0;
  logic [1:0]  wbrd1, wbrd0;
  logic [3:0]  wbd1, wbd0, dbg1, dbg0;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] m_r [4];
  logic       m_zf1, m_zf0;

  always #5 clk = ~clk;

  // ALU map: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 NOT a.
  function automatic logic [3:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0:    alu_f = a + b;
      3'd1:    alu_f = a - b;
      3'd2:    alu_f = a & b;
      3'd3:    alu_f = a | b;
      3'd4:    alu_f = ~a;
      default: alu_f = 4'd0;
    endcase
  endfunction

  assign res1 = alu_f(a1, b1, op1);
  assign res0 = alu_f(a0, b0, op0);

  alu_issue_ctrl #(.LDI_SETS_ZERO(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_instr(in_instr), .alu_a(a1), .alu_b(b1), .alu_op(op1),
    .alu_result(res1), .alu_zero(res1 == 4'd0), .wb_valid(wbv1), .wb_rd(wbrd1),
    .wb_data(wbd1), .zero_flag(zf1), .halted(halted1), .dbg_addr(dbg_addr),
    .dbg_data(dbg1)
  );

  alu_issue_ctrl #(.LDI_SETS_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_instr(in_instr), .alu_a(a0), .alu_b(b0), .alu_op(op0),
    .alu_result(res0), .alu_zero(res0 == 4'd0), .wb_valid(wbv0), .wb_rd(wbrd0),
    .wb_data(wbd0), .zero_flag(zf0), .halted(halted0), .dbg_addr(dbg_addr),
    .dbg_data(dbg0)
  );

  function automatic logic [11:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs1, input logic [1:0] rs2,
                                     input logic [3:0] imm);
    if (op == 3'd5) mk = {op, rd, rs1, 1'b0, imm};
    else            mk = {op, rd, rs1, rs2, 3'b000};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 4'd0;
    m_zf1 = 1'b0;
    m_zf0 = 1'b0;
  endtask

  // Issue one instruction, check operands in EXEC and writeback the cycle after.
  task automatic exec_instr(input logic [11:0] ins, input bit keep_valid);
    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [3:0] imm, ea, eb, eres;
    logic [2:0] eop;
    op = ins[11:9]; rd = ins[8:7]; rs1 = ins[6:5]; rs2 = ins[4:3]; imm = ins[3:0];
    if (op == 3'd5)      begin ea = imm; eb = 4'd0; eop = 3'b001; eres = imm; end
    else if (op >= 3'd6) begin ea = 4'd0; eb = 4'd0; eop = 3'b000; eres = 4'd0; end
    else begin
      ea = m_r[rs1]; eb = m_r[rs2]; eop = op;
      case (op)
        3'd0: eres = m_r[rs1] + m_r[rs2];
        3'd1: eres = m_r[rs1] - m_r[rs2];
        3'd2: eres = m_r[rs1] & m_r[rs2];
        3'd3: eres = m_r[rs1] | m_r[rs2];
        default: eres = ~m_r[rs1];
      endcase
    end
    for (int i = 0; i < 8 && !in_ready1; i++) begin @(posedge clk); #1; end
    n_vec++;
    if (in_ready1 !== 1'b1) begin
      n_err++; $display("FAIL ready_timeout: in_ready=%b required 1", in_ready1);
    end
    in_valid = 1'b1;
    in_instr = ins;
    dbg_addr = rd;
    @(posedge clk); #1;
    if (!keep_valid) in_valid = 1'b0;
    if (op == 3'd7) begin
      n_vec++;
      if (halted1 !== 1'b1 || halted0 !== 1'b1 || in_ready1 !== 1'b0) begin
        n_err++; $display("FAIL halt_enter: halted=%b/%b in_ready=%b required 1/1 0", halted1, halted0, in_ready1);
      end
      return;
    end
    n_vec++;
    if (in_ready1 !== 1'b0 || in_ready0 !== 1'b0) begin
      n_err++; $display("FAIL exec_ready: in_ready=%b/%b required 0", in_ready1, in_ready0);
    end
    n_vec++;
    if (a1 !== ea || b1 !== eb || op1 !== eop || a0 !== ea || b0 !== eb || op0 !== eop) begin
      n_err++; $display("FAIL operands: a=%h b=%h op=%h (dut0 %h %h %h) required a=%h b=%h op=%h",
                        a1, b1, op1, a0, b0, op0, ea, eb, eop);
    end
    @(posedge clk); #1;
    if (op <= 3'd5) begin
      m_r[rd] = eres;
      if (op != 3'd5) begin m_zf1 = (eres == 4'd0); m_zf0 = (eres == 4'd0); end
      else m_zf1 = (eres == 4'd0);
      n_vec++;
      if (wbv1 !== 1'b1 || wbrd1 !== rd || wbd1 !== eres || wbv0 !== 1'b1 || wbrd0 !== rd || wbd0 !== eres) begin
        n_err++; $display("FAIL writeback: v=%b rd=%0d data=%h (dut0 %b %0d %h) required 1 %0d %h",
                          wbv1, wbrd1, wbd1, wbv0, wbrd0, wbd0, rd, eres);
      end
    end else begin
      n_vec++;
      if (wbv1 !== 1'b0 || wbv0 !== 1'b0) begin
        n_err++; $display("FAIL nop_wb: wb_valid=%b/%b required 0", wbv1, wbv0);
      end
    end
    n_vec++;
    if (zf1 !== m_zf1 || zf0 !== m_zf0) begin
      n_err++; $display("FAIL zero_flag: %b/%b required %b/%b", zf1, zf0, m_zf1, m_zf0);
    end
    n_vec++;
    if (dbg1 !== m_r[rd] || dbg0 !== m_r[rd] || in_ready1 !== 1'b1) begin
      n_err++; $display("FAIL dbg_after_wb: dbg=%h/%h in_ready=%b required %h 1", dbg1, dbg0, in_ready1, m_r[rd]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    n_vec++;
    if (in_ready1 !== 1'b1 || halted1 !== 1'b0 || wbv1 !== 1'b0 || wbrd1 !== 2'd0 || wbd1 !== 4'd0 ||
        zf1 !== 1'b0 || a1 !== 4'd0 || b1 !== 4'd0 || op1 !== 3'd0 || halted0 !== 1'b0 || wbv0 !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: rdy=%b halt=%b wbv=%b rd=%0d d=%h zf=%b a=%h b=%h op=%h required 1 0 0 0 0 0 0 0 0",
                        in_ready1, halted1, wbv1, wbrd1, wbd1, zf1, a1, b1, op1);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = i[1:0];
      #1;
      n_vec++;
      if (dbg1 !== 4'd0 || dbg0 !== 4'd0) begin
        n_err++; $display("FAIL reset_reg R%0d: %h/%h required 0", i, dbg1, dbg0);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) begin
      n_err++; $display("FAIL ready_after_reset: %b/%b required 1", in_ready1, in_ready0);
    end
  endtask

  task automatic check_reg(input logic [1:0] r, input logic [3:0] v);
    dbg_addr = r;
    #1;
    n_vec++;
    if (dbg1 !== v) begin
      n_err++; $display("FAIL reg R%0d: %h required %h", r, dbg1, v);
    end
  endtask

  task automatic test_ldi_add();
    exec_instr(mk(3'd5, 2'd1, 2'd0, 2'd0, 4'd5), 1'b0);
    exec_instr(mk(3'd5, 2'd2, 2'd0, 2'd0, 4'd3), 1'b0);
    exec_instr(mk(3'd0, 2'd3, 2'd1, 2'd2, 4'd0), 1'b0);
    check_reg(2'd3, 4'd8);
    n_vec++;
    if (zf1 !== 1'b0) begin n_err++; $display("FAIL add_zero: %b required 0", zf1); end
  endtask

  task automatic test_sub_zero();
    exec_instr(mk(3'd5, 2'd1, 2'd0, 2'd0, 4'd9), 1'b0);
    exec_instr(mk(3'd1, 2'd0, 2'd1, 2'd1, 4'd0), 1'b0);
    n_vec++;
    if (zf1 !== 1'b1 || zf0 !== 1'b1) begin n_err++; $display("FAIL sub_zero: %b/%b required 1/1", zf1, zf0); end
    exec_instr(mk(3'd5, 2'd2, 2'd0, 2'd0, 4'd4), 1'b0);
    n_vec++;
    if (zf0 !== 1'b1 || zf1 !== 1'b0) begin n_err++; $display("FAIL ldi_zero_param: %b/%b required 0/1", zf1, zf0); end
  endtask

  task automatic test_wrap();
    exec_instr(mk(3'd5, 2'd1, 2'd0, 2'd0, 4'd15), 1'b0);
    exec_instr(mk(3'd0, 2'd1, 2'd1, 2'd1, 4'd0), 1'b0);
    check_reg(2'd1, 4'd14);
    exec_instr(mk(3'd4, 2'd2, 2'd1, 2'd0, 4'd0), 1'b0);
    check_reg(2'd2, 4'd1);
  endtask

  task automatic test_back_to_back();
    exec_instr(mk(3'd5, 2'd0, 2'd0, 2'd0, 4'd6), 1'b1);
    exec_instr(mk(3'd6, 2'd1, 2'd0, 2'd0, 4'd0), 1'b1);
    exec_instr(mk(3'd0, 2'd1, 2'd0, 2'd0, 4'd0), 1'b1);
    exec_instr(mk(3'd3, 2'd2, 2'd1, 2'd0, 4'd0), 1'b0);
    check_reg(2'd1, 4'd12);
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      exec_instr(mk(3'($urandom_range(0, 6)), 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom)), 1'b0);
    end
  endtask

  task automatic test_halt();
    exec_instr(mk(3'd7, 2'd0, 2'd0, 2'd0, 4'd0), 1'b0);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1;
      in_instr = mk(3'($urandom_range(0, 5)), 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));
      @(posedge clk); #1;
      n_vec++;
      if (halted1 !== 1'b1 || in_ready1 !== 1'b0 || wbv1 !== 1'b0 || wbv0 !== 1'b0) begin
        n_err++; $display("FAIL halt_hold %0d: halted=%b in_ready=%b wb_valid=%b required 1 0 0", k, halted1, in_ready1, wbv1);
      end
    end
    in_valid = 1'b0;
    test_reset();
    n_vec++;
    if (halted1 !== 1'b0 || halted0 !== 1'b0) begin n_err++; $display("FAIL halt_clear: %b/%b required 0", halted1, halted0); end
  endtask

  task automatic test_reset_in_exec();
    exec_instr(mk(3'd5, 2'd1, 2'd0, 2'd0, 4'd2), 1'b0);
    in_valid = 1'b1;
    in_instr = mk(3'd5, 2'd3, 2'd0, 2'd0, 4'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (wbv1 !== 1'b0 || wbv0 !== 1'b0) begin n_err++; $display("FAIL abort_wb %0d: %b/%b required 0", k, wbv1, wbv0); end
    end
    check_reg(2'd3, 4'd0);
    check_reg(2'd1, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    test_reset();
    test_ldi_add();
    test_sub_zero();
    test_wrap();
    test_back_to_back();
    test_random();
    test_reset_in_exec();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
